// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router datapath.
//   DATA_WIDTH_DEF : default byte width
//   ERR_CNT_W      : width of the optional parity-error counter
//   router_state_e : control FSM state encoding (the register stage itself
//                    only sees one-hot strobes decoded from it)
package router_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ERR_CNT_W      = 16;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'b000,
    LOAD_FIRST_DATA    = 3'b001,
    LOAD_DATA          = 3'b010,
    LOAD_PARITY        = 3'b011,
    FIFO_FULL_STATE    = 3'b100,
    LOAD_AFTER_FULL    = 3'b101,
    CHECK_PARITY_ERROR = 3'b110,
    WAIT_TILL_EMPTY    = 3'b111
  } router_state_e;
endpackage

// File: rtl/router_parity_acc.sv
// Running-parity accumulator, packet parity capture and comparator.
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   detect_add .. laf_state: FSM state strobes
//   pkt_valid, fifo_full   : source valid / addressed FIFO full
//   low_packet_valid       : parity byte has been seen (from top)
//   parity_done            : parity byte captured (from top)
//   data_in, header_byte,
//   full_hold              : candidate bytes to fold / capture
//   err                    : registered parity mismatch flag
module router_parity_acc
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  detect_add,
  input  logic                  pkt_valid,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  fifo_full,
  input  logic                  low_packet_valid,
  input  logic                  parity_done,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] header_byte,
  input  logic [DATA_WIDTH-1:0] full_hold,
  output logic                  err
);
  logic [DATA_WIDTH-1:0] internal_parity;
  logic [DATA_WIDTH-1:0] packet_parity;
  logic                  err_pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      internal_parity <= '0;
      packet_parity   <= '0;
      err_pending     <= 1'b0;
      err             <= 1'b0;
    end else begin
      // The parity byte itself is never folded in: a held byte replayed in
      // LOAD_AFTER_FULL is only accumulated while it is still payload.
      if (detect_add)                          internal_parity <= '0;
      else if (lfd_state)                      internal_parity <= internal_parity ^ header_byte;
      else if (ld_state && pkt_valid && !fifo_full)
                                               internal_parity <= internal_parity ^ data_in;
      else if (laf_state && !low_packet_valid) internal_parity <= internal_parity ^ full_hold;

      if (ld_state && !pkt_valid && !fifo_full)
        packet_parity <= data_in;
      else if (laf_state && low_packet_valid && !parity_done)
        packet_parity <= full_hold;

      err_pending <= parity_done;
      // Compare on the rising edge of parity_done. This wins over the clear so
      // a LOAD_AFTER_FULL -> DECODE_ADDRESS path still reports the result.
      if (parity_done && !err_pending)  err <= (internal_parity != packet_parity);
      else if (detect_add && pkt_valid) err <= 1'b0;
    end
  end
endmodule

// File: rtl/router_reg.sv
// Datapath register stage of the 1x3 router: header latch, FIFO write
// staging with a one-byte hold across a FIFO-full stall, parity tracking.
// Optional macro ROUTER_ERR_COUNT_EN adds a saturating err_count output.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   pkt_valid, data_in      : source valid and byte bus
//   fifo_full               : full flag of addressed output FIFO
//   detect_add .. rst_int_reg: one-hot FSM state strobes
//   dout                    : byte to FIFO write port
//   parity_done             : packet parity byte captured
//   low_packet_valid        : pkt_valid fell during LOAD_DATA
//   err                     : parity mismatch
//   err_count (optional)    : number of err 0->1 transitions
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_done,
  output logic                  low_packet_valid,
  output logic                  err
`ifdef ROUTER_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0]  err_count
`endif
);
  logic [DATA_WIDTH-1:0] header_byte;
  logic [DATA_WIDTH-1:0] full_hold;
  logic                  pd_set;

  assign pd_set = (ld_state && !fifo_full && !pkt_valid) ||
                  (laf_state && low_packet_valid && !parity_done);

  // full_state needs no branch: every register simply keeps its value.
  always_ff @(posedge clock) begin
    if (reset) begin
      header_byte      <= '0;
      full_hold        <= '0;
      dout             <= '0;
      low_packet_valid <= 1'b0;
      parity_done      <= 1'b0;
    end else begin
      if (detect_add && pkt_valid) header_byte <= data_in;

      if (lfd_state)                  dout <= header_byte;
      else if (ld_state && !fifo_full) dout <= data_in;
      else if (laf_state)             dout <= full_hold;

      if (ld_state && fifo_full) full_hold <= data_in;

      if (detect_add || rst_int_reg)  low_packet_valid <= 1'b0;
      else if (ld_state && !pkt_valid) low_packet_valid <= 1'b1;

      if (pd_set)          parity_done <= 1'b1;
      else if (detect_add) parity_done <= 1'b0;
    end
  end

  router_parity_acc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .clock            (clock),
    .reset            (reset),
    .detect_add       (detect_add),
    .pkt_valid        (pkt_valid),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .fifo_full        (fifo_full),
    .low_packet_valid (low_packet_valid),
    .parity_done      (parity_done),
    .data_in          (data_in),
    .header_byte      (header_byte),
    .full_hold        (full_hold),
    .err              (err)
  );

`ifdef ROUTER_ERR_COUNT_EN
  logic err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q     <= 1'b0;
      err_count <= '0;
    end else begin
      err_q <= err;
      if (err && !err_q && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_router_reg.sv
module tb_router_reg;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       reset, pkt_valid, fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] data_in, dout;
  logic       parity_done, low_packet_valid, err;
`ifdef ROUTER_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int n_bad   = 0;   // expected err 0->1 transitions

  router_reg #(.DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .err(err)
`ifdef ROUTER_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          rst;
    router_state_e st;
    logic          pv;
    logic          ff;
    logic [7:0]    din;
    logic [7:0]    e_dout;
    logic          e_pd;
    logic          e_lpv;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, router_state_e s, logic pv, logic ff, logic [7:0] d,
                              logic [7:0] ed, logic epd, logic elpv, logic eerr);
    vec_t v;
    v.rst = r; v.st = s; v.pv = pv; v.ff = ff; v.din = d;
    v.e_dout = ed; v.e_pd = epd; v.e_lpv = elpv; v.e_err = eerr;
    return v;
  endfunction

  // One clock with the FSM in state st; outputs sampled 1 time unit later.
  task automatic drive(input logic rst, input router_state_e st, input logic pv,
                       input logic ff, input logic [7:0] din);
    reset       = rst;
    pkt_valid   = pv;
    fifo_full   = ff;
    data_in     = din;
    detect_add  = (st == DECODE_ADDRESS);
    lfd_state   = (st == LOAD_FIRST_DATA);
    ld_state    = (st == LOAD_DATA);
    laf_state   = (st == LOAD_AFTER_FULL);
    full_state  = (st == FIFO_FULL_STATE);
    rst_int_reg = (st == CHECK_PARITY_ERROR);
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Normal packet: header 05, payload A3, parity A6 (no error).
  task automatic push_good_pkt();
    vecs.push_back(mk(0, DECODE_ADDRESS,     1, 0, 8'h05, 8'hA6, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_FIRST_DATA,    1, 0, 8'h00, 8'h05, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_DATA,          1, 0, 8'hA3, 8'hA3, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_DATA,          0, 0, 8'hA6, 8'hA6, 1, 1, 0));
    vecs.push_back(mk(0, CHECK_PARITY_ERROR, 0, 0, 8'h00, 8'hA6, 1, 0, 0));
    vecs.push_back(mk(0, WAIT_TILL_EMPTY,    0, 0, 8'h00, 8'hA6, 1, 0, 0));
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] hdr, par, xr, last;
    logic       exp_err, pv, ff, stalled;
    logic       prev_e_err;
    int         len;

    reset = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0; data_in = '0;
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0; full_state = 0; rst_int_reg = 0;

    // ---------------- directed table ----------------
    vecs.push_back(mk(1, WAIT_TILL_EMPTY, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    push_good_pkt();
    vecs[1].e_dout = 8'h00;  // first header after reset: dout still 0
    // bad parity 00
    vecs.push_back(mk(0, DECODE_ADDRESS,     1, 0, 8'h05, 8'hA6, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_FIRST_DATA,    1, 0, 8'h00, 8'h05, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_DATA,          1, 0, 8'hA3, 8'hA3, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_DATA,          0, 0, 8'h00, 8'h00, 1, 1, 0));
    vecs.push_back(mk(0, CHECK_PARITY_ERROR, 0, 0, 8'h00, 8'h00, 1, 0, 1));
    vecs.push_back(mk(0, WAIT_TILL_EMPTY,    0, 0, 8'h00, 8'h00, 1, 0, 1));
    // next header clears err; stall on parity byte 5A (wrong: expected A6)
    vecs.push_back(mk(0, DECODE_ADDRESS,     1, 0, 8'h05, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_FIRST_DATA,    1, 0, 8'h00, 8'h05, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_DATA,          1, 0, 8'hA3, 8'hA3, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_DATA,          0, 1, 8'h5A, 8'hA3, 0, 1, 0));
    vecs.push_back(mk(0, FIFO_FULL_STATE,    0, 1, 8'h00, 8'hA3, 0, 1, 0));
    vecs.push_back(mk(0, LOAD_AFTER_FULL,    0, 0, 8'h00, 8'h5A, 1, 1, 0));
    vecs.push_back(mk(0, WAIT_TILL_EMPTY,    0, 0, 8'h00, 8'h5A, 1, 1, 1));
    // stall mid-payload on 3C, parity 05^3C=39
    vecs.push_back(mk(0, DECODE_ADDRESS,     1, 0, 8'h05, 8'h5A, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_FIRST_DATA,    1, 0, 8'h00, 8'h05, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_DATA,          1, 1, 8'h3C, 8'h05, 0, 0, 0));
    vecs.push_back(mk(0, FIFO_FULL_STATE,    0, 1, 8'h00, 8'h05, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_AFTER_FULL,    0, 0, 8'h00, 8'h3C, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_DATA,          0, 0, 8'h39, 8'h39, 1, 1, 0));
    vecs.push_back(mk(0, CHECK_PARITY_ERROR, 0, 0, 8'h00, 8'h39, 1, 0, 0));
    // reset mid-payload
    vecs.push_back(mk(0, DECODE_ADDRESS,     1, 0, 8'h05, 8'h39, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_FIRST_DATA,    1, 0, 8'h00, 8'h05, 0, 0, 0));
    vecs.push_back(mk(0, LOAD_DATA,          1, 0, 8'hA3, 8'hA3, 0, 0, 0));
    vecs.push_back(mk(1, LOAD_DATA,          1, 0, 8'h77, 8'h00, 0, 0, 0));
    push_good_pkt();
    vecs[vecs.size()-6].e_dout = 8'h00;

    prev_e_err = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].pv, vecs[i].ff, vecs[i].din);
      check($sformatf("vec%0d {dout,pd,lpv,err}", i),
            {5'd0, dout, parity_done, low_packet_valid, err},
            {5'd0, vecs[i].e_dout, vecs[i].e_pd, vecs[i].e_lpv, vecs[i].e_err});
      if (vecs[i].e_err && !prev_e_err) n_bad++;
      prev_e_err = vecs[i].rst ? 1'b0 : vecs[i].e_err;
    end

    // ---------------- random packets vs. packet-level model ----------------
    // Model: the FIFO must see header, payload..., parity in order; err is
    // the XOR of header and payload compared with the parity byte.
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 6);
      hdr = 8'($urandom);
      xr  = hdr;
      q   = {};
      for (int k = 0; k < len; k++) begin
        q.push_back(8'($urandom));
        xr ^= q[k];
      end
      par = xr;
      if ($urandom_range(0, 2) == 0) par = xr ^ 8'($urandom_range(1, 255));
      exp_err = (par != xr);
      q.push_back(par);

      drive(0, DECODE_ADDRESS, 1, 0, hdr);
      drive(0, LOAD_FIRST_DATA, 1, 0, 8'h00);
      check($sformatf("pkt%0d header", p), {8'd0, dout}, {8'd0, hdr});
      last    = hdr;
      stalled = 1'b0;
      for (int k = 0; k <= len; k++) begin
        pv = (k < len);
        ff = ($urandom_range(0, 3) == 0);
        drive(0, LOAD_DATA, pv, ff, q[k]);
        if (ff) begin
          check($sformatf("pkt%0d hold b%0d", p, k), {8'd0, dout}, {8'd0, last});
          repeat ($urandom_range(0, 2)) drive(0, FIFO_FULL_STATE, 0, 1, 8'h00);
          drive(0, LOAD_AFTER_FULL, 0, 0, 8'h00);
        end
        check($sformatf("pkt%0d byte%0d", p, k), {8'd0, dout}, {8'd0, q[k]});
        last    = q[k];
        stalled = ff;
      end
      if (!stalled) drive(0, CHECK_PARITY_ERROR, 0, 0, 8'h00);
      drive(0, WAIT_TILL_EMPTY, 0, 0, 8'h00);
      check($sformatf("pkt%0d pd/err", p), {14'd0, parity_done, err}, {14'd0, 1'b1, exp_err});
      if (exp_err) n_bad++;
    end

`ifdef ROUTER_ERR_COUNT_EN
    drive(0, WAIT_TILL_EMPTY, 0, 0, 8'h00);
    check("err_count", err_count, 16'(n_bad));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
